// File: rtl/ember_pkg.sv
// rtl/ember_pkg.sv - Shared Ember opcode constants and fetch state encoding
package ember_pkg;

    localparam logic [31:0] BUBBLE_INST   = 32'hFFF0_0000;
    localparam logic [11:0] OPC_ALU_LIMIT = 12'h100;
    localparam int          FLAG_IMM_BIT  = 0;

    typedef enum logic [2:0] {
        REQ_INST,
        WAIT_INST,
        REQ_IMM,
        WAIT_IMM,
        DRAIN
    } fetch_state_t;

    // ALU opcodes never carry an immediate, whatever their flag bits say
    function automatic logic carries_imm(input logic [31:0] word);
        return (word[31:20] >= OPC_ALU_LIMIT) && word[FLAG_IMM_BIT];
    endfunction

endpackage

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - Ember instruction fetch stage; FETCH_TRACE_EN enables trace prints
module fetch_unit
    import ember_pkg::*;
#(
    parameter int                DATA_W   = 64,
    parameter int                INST_W   = 32,
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_rdata,
    input  logic              imem_ack,
    input  logic              stall,
    input  logic              redirect_en,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic [INST_W-1:0] inst,
    output logic              inst_valid,
    output logic [ADDR_W-1:0] pc_out,
    output logic [DATA_W-1:0] imm_in,
    output logic              imm_in_en
);

    fetch_state_t      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] tgt_q, tgt_d;
    logic              req_q, req_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [INST_W-1:0] inst_q, inst_d;
    logic              inst_valid_q, inst_valid_d;
    logic [ADDR_W-1:0] pc_out_q, pc_out_d;
    logic [DATA_W-1:0] imm_q, imm_d;
    logic              imm_en_q, imm_en_d;
    logic [31:0]       imm_lo_q, imm_lo_d;
    logic              imm_cnt_q, imm_cnt_d;

    logic [ADDR_W-1:0] pc_plus4;
    logic [ADDR_W-1:0] redir_aligned;
    logic [63:0]       imm_full;
    logic              imm_last;

    assign pc_plus4      = pc_q + ADDR_W'(4);
    assign redir_aligned = {redirect_pc[ADDR_W-1:2], 2'b00};
    assign imm_full      = (DATA_W == 64) ? {imem_rdata, imm_lo_q} : {32'b0, imem_rdata};
    assign imm_last      = (DATA_W == 32) || imm_cnt_q;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        tgt_d        = tgt_q;
        req_d        = req_q;
        addr_d       = addr_q;
        inst_d       = BUBBLE_INST;
        inst_valid_d = 1'b0;
        pc_out_d     = pc_out_q;
        imm_d        = imm_q;
        imm_en_d     = 1'b0;
        imm_lo_d     = imm_lo_q;
        imm_cnt_d    = imm_cnt_q;

        case (state_q)
            REQ_INST: begin
                if (!stall) begin
                    req_d   = 1'b1;
                    addr_d  = pc_q;
                    state_d = WAIT_INST;
                end
            end
            WAIT_INST: begin
                if (imem_ack) begin
                    req_d        = 1'b0;
                    inst_d       = imem_rdata;
                    inst_valid_d = 1'b1;
                    pc_out_d     = pc_q;
                    pc_d         = pc_plus4;
                    imm_cnt_d    = 1'b0;
                    state_d      = carries_imm(imem_rdata) ? REQ_IMM : REQ_INST;
                end
            end
            REQ_IMM: begin
                req_d   = 1'b1;
                addr_d  = pc_q;
                state_d = WAIT_IMM;
            end
            WAIT_IMM: begin
                if (imem_ack) begin
                    req_d = 1'b0;
                    pc_d  = pc_plus4;
                    if (imm_last) begin
                        imm_d    = imm_full[DATA_W-1:0];
                        imm_en_d = 1'b1;
                        state_d  = REQ_INST;
                    end else begin
                        imm_lo_d  = imem_rdata;
                        imm_cnt_d = 1'b1;
                        state_d   = REQ_IMM;
                    end
                end
            end
            DRAIN: begin
                if (imem_ack) begin
                    req_d   = 1'b0;
                    pc_d    = tgt_q;
                    state_d = REQ_INST;
                end
            end
            default: state_d = REQ_INST;
        endcase

        // Redirect overrides everything; an in-flight request must still see its ack
        if (redirect_en) begin
            inst_d       = BUBBLE_INST;
            inst_valid_d = 1'b0;
            pc_out_d     = pc_out_q;
            imm_d        = imm_q;
            imm_en_d     = 1'b0;
            addr_d       = addr_q;
            if (req_q && !imem_ack) begin
                req_d   = 1'b1;
                tgt_d   = redir_aligned;
                state_d = DRAIN;
            end else begin
                req_d   = 1'b0;
                pc_d    = redir_aligned;
                state_d = REQ_INST;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= REQ_INST;
            pc_q         <= RESET_PC;
            tgt_q        <= RESET_PC;
            req_q        <= 1'b0;
            addr_q       <= RESET_PC;
            inst_q       <= BUBBLE_INST;
            inst_valid_q <= 1'b0;
            pc_out_q     <= RESET_PC;
            imm_q        <= '0;
            imm_en_q     <= 1'b0;
            imm_lo_q     <= '0;
            imm_cnt_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            tgt_q        <= tgt_d;
            req_q        <= req_d;
            addr_q       <= addr_d;
            inst_q       <= inst_d;
            inst_valid_q <= inst_valid_d;
            pc_out_q     <= pc_out_d;
            imm_q        <= imm_d;
            imm_en_q     <= imm_en_d;
            imm_lo_q     <= imm_lo_d;
            imm_cnt_q    <= imm_cnt_d;
        end
    end

`ifdef FETCH_TRACE_EN
    always_ff @(posedge clk) begin
        if (inst_valid_q) $display("[FETCH] PC: %h Inst: %h", pc_out_q, inst_q);
        if (imm_en_q)     $display("[FETCH] Imm: %h", imm_q);
    end
`else
`endif

    assign imem_req   = req_q;
    assign imem_addr  = addr_q;
    assign inst       = inst_q;
    assign inst_valid = inst_valid_q;
    assign pc_out     = pc_out_q;
    assign imm_in     = imm_q;
    assign imm_in_en  = imm_en_q;

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage feeding the Ember decoder. It walks the program counter, reads 32-bit words from instruction memory over a req/ack handshake, and presents each instruction word to the decoder's `inst` input for exactly one cycle. When an instruction carries a trailing immediate, it fetches the following word(s) and delivers them on `imm_in`/`imm_in_en`. Between instructions it drives a bubble encoding, and it accepts branch redirects from the execute stage.

## Interface
- `DATA_W`, 64: immediate width; legal values 32 or 64.
- `INST_W`, 32: instruction width; fixed at 32.
- `ADDR_W`, 32: byte-address width.
- `RESET_PC`, 0: PC after reset; 4-byte aligned.

- `clk`  in  1  clock; all logic on posedge.
- `rst`  in  1  synchronous, active-high reset.
- `imem_req`  out  1  read request; held until ack.
- `imem_addr`  out  ADDR_W  word-aligned byte address; stable while req is high.
- `imem_rdata`  in  32  read data; valid in the ack cycle.
- `imem_ack`  in  1  single-cycle completion.
- `stall`  in  1  blocks issue of a new request.
- `redirect_en`  in  1  one-cycle branch redirect.
- `redirect_pc`  in  ADDR_W  redirect target.
- `inst`  out  INST_W  to decoder; equals `BUBBLE_INST` when not valid.
- `inst_valid`  out  1  one-cycle pulse with a real instruction.
- `pc_out`  out  ADDR_W  address of the current `inst`.
- `imm_in`  out  DATA_W  immediate to decoder.
- `imm_in_en`  out  1  one-cycle pulse with the immediate.

## Operation
- Bubble instruction: `BUBBLE_INST` = 32'hFFF0_0000 (opcode 12'hFFF, flags 0). The decoder treats it as a no-op.
- Immediate-carrying instruction: `inst[31:20] >= 12'h100` and `inst[0] == 1`. ALU opcodes (< 12'h100) never carry an immediate, regardless of flags.
- State machine: REQ_INST, WAIT_INST, REQ_IMM, WAIT_IMM, DRAIN.
  - REQ_INST: if `!stall`, raise `imem_req` with `addr = pc`, then go to WAIT_INST. If `stall`, stay and leave req low.
  - WAIT_INST, on ack: drive `inst = rdata` with `inst_valid = 1` and `pc_out = pc`.
    - Immediate-carrying: set `pc += 4` and go to REQ_IMM.
    - Otherwise: set `pc += 4` and go to REQ_INST.
  - REQ_IMM / WAIT_IMM: fetch one word (DATA_W = 32) or two words, low then high (DATA_W = 64), at consecutive addresses.
    - On the last ack, drive `imm_in` and pulse `imm_in_en`, then go to REQ_INST with `pc` pointing past the immediate.
    - `stall` is ignored during an immediate fetch.
  - DRAIN: wait for the outstanding ack, discard its data, load `pc` from the saved redirect target, then go to REQ_INST.
- Redirect:
  - With no request outstanding: `pc <= redirect_pc` and go to REQ_INST.
  - With a request outstanding: save the target and go to DRAIN.
  - Any partially fetched immediate is dropped, and `imm_in_en` is not pulsed.
  - A redirect in the same cycle as an ack wins: the acked data is discarded and no pulse is emitted.
- Arithmetic: PC increments by 4 and wraps modulo 2^ADDR_W. `redirect_pc[1:0]` is ignored, and the target is forced to word alignment.

## Timing
- Reset values:
  - `imem_req` = 0, `imem_addr` = RESET_PC
  - `inst` = BUBBLE_INST, `inst_valid` = 0, `pc_out` = RESET_PC
  - `imm_in` = 0, `imm_in_en` = 0
  - state = REQ_INST, `pc` = RESET_PC
- The first `imem_req` rises in the cycle after `rst` deasserts.
- Reset mid-request abandons the transaction. The memory side must tolerate a dropped request.
- Outputs are registered. `inst` and `inst_valid` appear one cycle after the ack edge and last exactly one cycle, then `inst` returns to `BUBBLE_INST`.
- Minimum spacing: `imm_in_en` comes at least 2 cycles after its `inst_valid`. This satisfies the decoder, which waits for the immediate starting the cycle after it latches the instruction.
- Zero-wait memory (ack the cycle after req): one instruction every 2 cycles; an instruction with a 64-bit immediate takes 6 cycles.
- `imem_addr` changes only when `imem_req` is low or in the cycle after an ack.

## Configuration
- `FETCH_TRACE_EN`:
  - Defined: prints `$display("[FETCH] PC: %h Inst: %h", ...)` on every `inst_valid`, and `[FETCH] Imm: %h` on every `imm_in_en`.
  - Undefined: no display statements are compiled, and behaviour is otherwise identical.

## Structure
- Shared package `ember_pkg`:
  - `BUBBLE_INST`
  - `OPC_ALU_LIMIT` = 12'h100
  - `FLAG_IMM_BIT` = 0
  - fetch state enum `fetch_state_t`
- The decoder also uses the opcode constants from `ember_pkg`.
- Single module; no sub-module is warranted.

## Test plan
- Reset, zero-wait memory returning 32'h0050_0010 at address 0 → `inst_valid` pulse with `inst` = 32'h0050_0010 and `pc_out` = 0, next request to address 4, no `imm_in_en`.
- Word 32'h1000_0011 (LOAD with imm flag) at 0x0, then 0x1111_2222 at 0x4 and 0x3333_4444 at 0x8 → `imm_in` = 64'h3333_4444_1111_2222 with a single `imm_in_en` pulse, next fetch from 0xC.
- ALU word 32'h0010_0001 (flag set, opcode < 0x100) → no immediate fetch, next fetch from +4.
- `redirect_en` with `redirect_pc` = 0x40 while WAIT_INST with ack delayed 3 cycles → acked data discarded, no `inst_valid`, next request to 0x40.
- `stall` held 5 cycles in REQ_INST → `imem_req` stays low throughout; request issued the cycle after `stall` drops.
- `rst` asserted during WAIT_IMM → all outputs return to reset values, and fetch restarts at RESET_PC.
